// File: rtl/icache_nway.sv
// N-way set-associative, read-only instruction cache with a registered refill FSM.
//
// Hits return in the request cycle. A miss latches the line-aligned address, requests one full
// line from memory and bypasses the requested word to the fetch stage in the cycle the line
// arrives. Replacement prefers the lowest invalid way, otherwise a per-set round-robin pointer.
// Flush invalidates every line; a flush seen during a refill is deferred until the refill ends.
//
// Ports:
//   clk_i            clock, rising edge
//   rstn_i           synchronous active-low reset
//   addr_i           fetch byte address
//   read_en_i        fetch request
//   flush_i          invalidate all lines (single-cycle pulse)
//   read_valid_o     read_word_o valid this cycle
//   read_word_o      fetched word
//   mem_addr_o       line-aligned refill address
//   mem_read_en_o    refill request, held until mem_read_valid_i
//   mem_read_valid_i refill line valid (one-cycle pulse)
//   mem_read_data_i  refill line, word k at [32k+31:32k]
//   hit_count_o      saturating hit counter
//   miss_count_o     saturating miss counter
module icache_nway #(
    parameter int unsigned NrWays         = 2,
    parameter int unsigned NrSets         = 64,
    parameter int unsigned NrWordsPerLine = 4
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [31:0]                     addr_i,
    input  logic                            read_en_i,
    input  logic                            flush_i,
    output logic                            read_valid_o,
    output logic [31:0]                     read_word_o,
    output logic [31:0]                     mem_addr_o,
    output logic                            mem_read_en_o,
    input  logic                            mem_read_valid_i,
    input  logic [32*NrWordsPerLine-1:0]    mem_read_data_i,
    output logic [31:0]                     hit_count_o,
    output logic [31:0]                     miss_count_o
);

    localparam int unsigned OffsetBits = $clog2(NrWordsPerLine) + 2;
    localparam int unsigned IndexBits  = $clog2(NrSets);
    localparam int unsigned TagBits    = 32 - IndexBits - OffsetBits;
    localparam int unsigned LineSize   = 32 * NrWordsPerLine;
    localparam int unsigned WordBits   = OffsetBits - 2;
    localparam int unsigned WayBits    = (NrWays > 1) ? $clog2(NrWays) : 1;

    typedef enum logic [0:0] {StIdle, StRefill} state_e;

    state_e state_q, state_d;

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    logic [TagBits-1:0]  tag_q  [NrSets][NrWays];
    logic [LineSize-1:0] data_q [NrSets][NrWays];

    logic [NrSets-1:0][NrWays-1:0]  valid_q, valid_d;
    logic [NrSets-1:0][WayBits-1:0] rr_q, rr_d;
    logic                           flush_pend_q, flush_pend_d;
    logic [31:0]                    hit_cnt_q, hit_cnt_d;
    logic [31:0]                    miss_cnt_q, miss_cnt_d;
    logic [31:0]                    mem_addr_q, mem_addr_d;

    // Request address split.
    logic [TagBits-1:0]   req_tag;
    logic [IndexBits-1:0] req_idx;
    logic [WordBits-1:0]  req_word;

    assign req_tag  = addr_i[31 -: TagBits];
    assign req_idx  = addr_i[OffsetBits +: IndexBits];
    assign req_word = addr_i[OffsetBits-1:2];

    // Byte-within-word bits carry no information for a word-wide fetch.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    // Refill works only from the latched address, never from addr_i.
    logic [TagBits-1:0]   fill_tag;
    logic [IndexBits-1:0] fill_idx;

    assign fill_tag = mem_addr_q[31 -: TagBits];
    assign fill_idx = mem_addr_q[OffsetBits +: IndexBits];

    function automatic logic [31:0] pick_word(input logic [LineSize-1:0] line,
                                              input logic [WordBits-1:0] sel);
        logic [31:0] word;
        word = '0;
        for (int unsigned k = 0; k < NrWordsPerLine; k++) begin
            if (sel == WordBits'(k)) begin
                word = line[32*k +: 32];
            end
        end
        return word;
    endfunction

    // Tag lookup; at most one way can match.
    logic               hit;
    logic [WayBits-1:0] hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < NrWays; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WayBits'(w);
            end
        end
    end

    logic [31:0] hit_word;
    logic [31:0] bypass_word;

    assign hit_word    = pick_word(data_q[req_idx][hit_way], req_word);
    assign bypass_word = pick_word(mem_read_data_i, req_word);

    // Victim selection: lowest invalid way wins, otherwise the set's round-robin pointer.
    // Iterating downwards lets the lowest-index free way overwrite the earlier picks.
    logic [WayBits-1:0] victim;
    logic               victim_free;

    always_comb begin
        victim      = rr_q[fill_idx];
        victim_free = 1'b0;
        for (int w = int'(NrWays) - 1; w >= 0; w--) begin
            if (!valid_q[fill_idx][w]) begin
                victim      = WayBits'(w);
                victim_free = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (read_en_i && !hit) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                if (mem_read_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; everything is forced quiet while reset is asserted.
    always_comb begin
        read_valid_o  = 1'b0;
        read_word_o   = '0;
        mem_read_en_o = 1'b0;
        if (rstn_i) begin
            case (state_q)
                StIdle: begin
                    if (read_en_i && hit) begin
                        read_valid_o = 1'b1;
                        read_word_o  = hit_word;
                    end
                end
                StRefill: begin
                    mem_read_en_o = 1'b1;
                    if (mem_read_valid_i && read_en_i) begin
                        read_valid_o = 1'b1;
                        read_word_o  = bypass_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath next state: valid bits, replacement pointers, flush deferral, counters.
    always_comb begin
        valid_d      = valid_q;
        rr_d         = rr_q;
        flush_pend_d = flush_pend_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        mem_addr_d   = mem_addr_q;
        case (state_q)
            StIdle: begin
                if (read_en_i && hit && (hit_cnt_q != '1)) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end
                if (read_en_i && !hit) begin
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                    end
                    mem_addr_d = {req_tag, req_idx, {OffsetBits{1'b0}}};
                end
                // A same-cycle hit was already served from the pre-flush arrays.
                if (flush_i) begin
                    valid_d = '0;
                end
            end
            StRefill: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_read_valid_i) begin
                    if (flush_pend_q || flush_i) begin
                        // Deferred flush also drops the line being installed now.
                        valid_d      = '0;
                        flush_pend_d = 1'b0;
                    end else begin
                        valid_d[fill_idx][victim] = 1'b1;
                    end
                    // Pointer only advances when a live line was evicted.
                    if (!victim_free && (NrWays > 1)) begin
                        rr_d[fill_idx] = rr_q[fill_idx] + WayBits'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_q      <= '0;
            rr_q         <= '0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            mem_addr_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            rr_q         <= rr_d;
            flush_pend_q <= flush_pend_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Line install; a reset in the arrival cycle abandons the write.
    always_ff @(posedge clk_i) begin
        if (rstn_i && (state_q == StRefill) && mem_read_valid_i) begin
            tag_q[fill_idx][victim]  <= fill_tag;
            data_q[fill_idx][victim] <= mem_read_data_i;
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway at default parameters (2 ways, 64 sets, 4 words per line).
// Memory line at line address A holds word k = 0x90 + 16*(A>>12) + k.
module tb_icache_nway;

    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  addr;
    logic         read_en;
    logic         flush;
    logic         read_valid;
    logic [31:0]  read_word;
    logic [31:0]  mem_addr;
    logic         mem_read_en;
    logic         mem_read_valid;
    logic [127:0] mem_read_data;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    always #5 clk = ~clk;

    icache_nway dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .addr_i           (addr),
        .read_en_i        (read_en),
        .flush_i          (flush),
        .read_valid_o     (read_valid),
        .read_word_o      (read_word),
        .mem_addr_o       (mem_addr),
        .mem_read_en_o    (mem_read_en),
        .mem_read_valid_i (mem_read_valid),
        .mem_read_data_i  (mem_read_data),
        .hit_count_o      (hit_count),
        .miss_count_o     (miss_count)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hits = '0;
    logic [31:0] exp_misses = '0;

    typedef struct {
        logic [31:0] addr;
        int          lat;        // refill cycles before the line arrives
        bit          hit;
        bit          flush_mid;  // pulse flush_i in the first refill cycle
    } rd_vec_t;

    rd_vec_t vec [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] line_word(input logic [31:0] la, input int k);
        return 32'h90 + ((la >> 12) << 4) + 32'(k);
    endfunction

    function automatic logic [127:0] make_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = line_word(la, k);
        return l;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic do_read(input rd_vec_t v);
        logic [31:0] a;
        logic [31:0] la;
        logic [31:0] ew;
        a  = v.addr;
        la = {a[31:4], 4'h0};
        ew = line_word(la, int'(a[3:2]));
        @(negedge clk);
        addr    = a;
        read_en = 1'b1;
        #1;
        if (v.hit) begin
            check("hit_valid", {31'd0, read_valid}, 32'd1);
            check("hit_word", read_word, ew);
            check("hit_no_memreq", {31'd0, mem_read_en}, 32'd0);
            exp_hits = sat_inc(exp_hits);
        end else begin
            check("miss_valid", {31'd0, read_valid}, 32'd0);
            exp_misses = sat_inc(exp_misses);
            for (int c = 0; c < v.lat; c++) begin
                @(negedge clk);
                flush = v.flush_mid && (c == 0);
                #1;
                check("refill_memreq", {31'd0, mem_read_en}, 32'd1);
                check("refill_addr", mem_addr, la);
                check("refill_wait_valid", {31'd0, read_valid}, 32'd0);
            end
            @(negedge clk);
            flush          = v.flush_mid && (v.lat == 0);
            mem_read_valid = 1'b1;
            mem_read_data  = make_line(la);
            #1;
            check("arrive_memreq", {31'd0, mem_read_en}, 32'd1);
            check("arrive_addr", mem_addr, la);
            check("bypass_valid", {31'd0, read_valid}, 32'd1);
            check("bypass_word", read_word, ew);
        end
        @(negedge clk);
        read_en        = 1'b0;
        flush          = 1'b0;
        mem_read_valid = 1'b0;
        mem_read_data  = '0;
        #1;
        check("idle_memreq", {31'd0, mem_read_en}, 32'd0);
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Cold fill, conflict and round-robin replacement in set 0.
        vec[0]  = '{32'h0000_1004, 3, 1'b0, 1'b0};
        vec[1]  = '{32'h0000_1008, 0, 1'b1, 1'b0};
        vec[2]  = '{32'h0000_2000, 1, 1'b0, 1'b0};  // lowest free way 1
        vec[3]  = '{32'h0000_1000, 0, 1'b1, 1'b0};
        vec[4]  = '{32'h0000_2000, 0, 1'b1, 1'b0};
        vec[5]  = '{32'h0000_3000, 2, 1'b0, 1'b0};  // evicts way 0 (0x1000), rr 0->1
        vec[6]  = '{32'h0000_1000, 1, 1'b0, 1'b0};  // evicts way 1 (0x2000), rr 1->0
        vec[7]  = '{32'h0000_3000, 0, 1'b1, 1'b0};
        vec[8]  = '{32'h0000_2000, 0, 1'b0, 1'b0};  // evicts way 0 (0x3000)
        vec[9]  = '{32'h0000_1000, 0, 1'b1, 1'b0};
        // After the idle flush.
        vec[10] = '{32'h0000_1004, 1, 1'b0, 1'b0};
        vec[11] = '{32'h0000_2004, 2, 1'b0, 1'b1};  // flush during refill
        vec[12] = '{32'h0000_2004, 0, 1'b0, 1'b0};  // line was dropped by deferred flush
        vec[13] = '{32'h0000_1004, 0, 1'b0, 1'b0};
        // After reset mid-refill.
        vec[14] = '{32'h0000_3004, 1, 1'b0, 1'b0};

        rstn           = 1'b0;
        addr           = 32'h0000_1004;
        read_en        = 1'b1;
        flush          = 1'b0;
        mem_read_valid = 1'b0;
        mem_read_data  = '0;

        // Reset: outputs quiet while held, state cleared after the edge.
        @(negedge clk);
        #1;
        check("rst_valid", {31'd0, read_valid}, 32'd0);
        check("rst_word", read_word, 32'd0);
        check("rst_memreq", {31'd0, mem_read_en}, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        check("rst_memaddr", mem_addr, 32'd0);
        @(negedge clk);
        rstn    = 1'b1;
        read_en = 1'b0;

        for (int i = 0; i < 10; i++) do_read(vec[i]);

        // Flush in IDLE with a same-cycle hit: served from pre-flush state.
        @(negedge clk);
        addr    = 32'h0000_1004;
        read_en = 1'b1;
        flush   = 1'b1;
        #1;
        check("flush_hit_valid", {31'd0, read_valid}, 32'd1);
        check("flush_hit_word", read_word, 32'h0000_00A1);
        exp_hits = sat_inc(exp_hits);
        @(negedge clk);
        read_en = 1'b0;
        flush   = 1'b0;
        #1;
        check("flush_hit_count", hit_count, exp_hits);

        for (int i = 10; i < 14; i++) do_read(vec[i]);

        // Reset during REFILL, then a late line arrival that must be ignored.
        @(negedge clk);
        addr    = 32'h0000_3004;
        read_en = 1'b1;
        #1;
        check("rstmid_miss", {31'd0, read_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("rstmid_memreq_before", {31'd0, mem_read_en}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rstmid_memreq_low", {31'd0, mem_read_en}, 32'd0);
        check("rstmid_valid_low", {31'd0, read_valid}, 32'd0);
        @(negedge clk);
        rstn           = 1'b1;
        read_en        = 1'b0;
        mem_read_valid = 1'b1;
        mem_read_data  = make_line(32'h0000_3000);
        #1;
        check("late_valid", {31'd0, read_valid}, 32'd0);
        check("late_memreq", {31'd0, mem_read_en}, 32'd0);
        check("rstmid_hits", hit_count, 32'd0);
        check("rstmid_misses", miss_count, 32'd0);
        check("rstmid_memaddr", mem_addr, 32'd0);
        @(negedge clk);
        mem_read_valid = 1'b0;
        mem_read_data  = '0;
        exp_hits       = '0;
        exp_misses     = '0;
        do_read(vec[14]);

        // read_en dropped during REFILL: no word returned, line still installed.
        @(negedge clk);
        addr    = 32'h0000_0010;
        read_en = 1'b1;
        #1;
        check("drop_miss", {31'd0, read_valid}, 32'd0);
        exp_misses = sat_inc(exp_misses);
        @(negedge clk);
        read_en = 1'b0;
        #1;
        check("drop_memreq", {31'd0, mem_read_en}, 32'd1);
        check("drop_addr", mem_addr, 32'h0000_0010);
        @(negedge clk);
        mem_read_valid = 1'b1;
        mem_read_data  = make_line(32'h0000_0010);
        #1;
        check("drop_memreq_held", {31'd0, mem_read_en}, 32'd1);
        check("drop_no_valid", {31'd0, read_valid}, 32'd0);
        @(negedge clk);
        mem_read_valid = 1'b0;
        mem_read_data  = '0;
        #1;
        check("drop_memreq_off", {31'd0, mem_read_en}, 32'd0);
        check("drop_misses", miss_count, exp_misses);
        do_read('{32'h0000_0014, 0, 1'b1, 1'b0});

        // Hit counter saturation: preload near the top, then three hits.
        @(negedge clk);
        force dut.hit_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.hit_cnt_q;
        exp_hits = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) do_read('{32'h0000_0018, 0, 1'b1, 1'b0});
        check("sat_final", hit_count, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
